// File: rtl/cpu_defs.sv
// Shared encodings and datapath defaults for the scalar MIPS core.
package cpu_defs;

    localparam int DW_DEF = 32;
    localparam int RW_DEF = 5;

    localparam logic [RW_DEF-1:0] REG_ZERO = '0;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_NOR = 3'd5,
        ALU_SLT = 3'd6,
        ALU_SFT = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2,
        SH_ROR = 2'd3
    } shift_e;

endpackage

// File: rtl/fwd_mux.sv
// Operand bypass selector: EX result beats MEM result beats regfile; $0 never bypassed.
module fwd_mux
    import cpu_defs::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic [RW-1:0] i_src_addr,
    input  logic [DW-1:0] i_rf_data,
    input  logic          i_ex_fwd_en,
    input  logic [RW-1:0] i_ex_addr,
    input  logic [DW-1:0] i_ex_data,
    input  logic          i_mem_fwd_en,
    input  logic [RW-1:0] i_mem_addr,
    input  logic [DW-1:0] i_mem_data,
    output logic [DW-1:0] o_operand
);

    logic w_src_nz;
    logic w_ex_hit;
    logic w_mem_hit;

    assign w_src_nz  = (i_src_addr != RW'(REG_ZERO));
    assign w_ex_hit  = i_ex_fwd_en  && w_src_nz && (i_ex_addr  == i_src_addr);
    assign w_mem_hit = i_mem_fwd_en && w_src_nz && (i_mem_addr == i_src_addr);

    assign o_operand = w_ex_hit  ? i_ex_data  :
                       w_mem_hit ? i_mem_data :
                                   i_rf_data;

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with operand forwarding and load-use bubble insertion.
// Optional stall/bubble performance counters are enabled by defining ID_EX_PERF_EN.
module id_ex_stage
    import cpu_defs::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    output logic          id_ready,
    input  logic [2:0]    id_alu_sel,
    input  logic [1:0]    id_shift,
    input  logic [4:0]    id_shamt,
    input  logic [RW-1:0] id_rs_addr,
    input  logic [RW-1:0] id_rt_addr,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic          id_use_imm,
    input  logic          id_wb_en,
    input  logic [RW-1:0] id_wb_addr,
    input  logic          id_is_load,
    input  logic          flush,
    input  logic          ex_ready,
    input  logic [DW-1:0] ex_alu_res,
    input  logic          mem_wb_en,
    input  logic [RW-1:0] mem_wb_addr,
    input  logic [DW-1:0] mem_wb_data,
    output logic          ex_valid,
    output logic [2:0]    W_alu_sel,
    output logic [1:0]    W_shift,
    output logic [4:0]    W_shamt,
    output logic [DW-1:0] W_rs,
    output logic [DW-1:0] W_rt,
    output logic          ex_wb_en,
    output logic [RW-1:0] ex_wb_addr,
`ifdef ID_EX_PERF_EN
    output logic [31:0]   perf_stall_cnt,
    output logic [31:0]   perf_bubble_cnt,
`endif
    output logic          ex_is_load
);

    logic          r_valid;
    logic [2:0]    r_alu_sel;
    logic [1:0]    r_shift;
    logic [4:0]    r_shamt;
    logic [DW-1:0] r_rs;
    logic [DW-1:0] r_rt;
    logic          r_wb_en;
    logic [RW-1:0] r_wb_addr;
    logic          r_is_load;

    logic          w_ex_fwd_en;
    logic          w_ex_dst_nz;
    logic          w_load_use;
    logic          w_id_ready;
    logic          w_capture;
    logic          w_clear;
    logic          w_bubble;
    logic [DW-1:0] w_rs_fwd;
    logic [DW-1:0] w_rt_fwd;
    logic [DW-1:0] w_rt_op;

    // A load's data is not ready in EX, so only non-load results bypass from here.
    assign w_ex_fwd_en = r_valid && r_wb_en && !r_is_load;
    assign w_ex_dst_nz = (r_wb_addr != RW'(REG_ZERO));

    assign w_load_use = r_valid && r_is_load && r_wb_en && w_ex_dst_nz &&
                        ((r_wb_addr == id_rs_addr) ||
                         (!id_use_imm && (r_wb_addr == id_rt_addr)));

    assign w_id_ready = ex_ready && !w_load_use;
    assign id_ready   = w_id_ready;

    assign w_bubble  = !flush && ex_ready && w_load_use;
    assign w_capture = !flush && ex_ready && !w_load_use && id_valid;
    assign w_clear   = flush || (ex_ready && !w_capture);

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
        .i_src_addr   (id_rs_addr),
        .i_rf_data    (id_rs_data),
        .i_ex_fwd_en  (w_ex_fwd_en),
        .i_ex_addr    (r_wb_addr),
        .i_ex_data    (ex_alu_res),
        .i_mem_fwd_en (mem_wb_en),
        .i_mem_addr   (mem_wb_addr),
        .i_mem_data   (mem_wb_data),
        .o_operand    (w_rs_fwd)
    );

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
        .i_src_addr   (id_rt_addr),
        .i_rf_data    (id_rt_data),
        .i_ex_fwd_en  (w_ex_fwd_en),
        .i_ex_addr    (r_wb_addr),
        .i_ex_data    (ex_alu_res),
        .i_mem_fwd_en (mem_wb_en),
        .i_mem_addr   (mem_wb_addr),
        .i_mem_data   (mem_wb_data),
        .o_operand    (w_rt_fwd)
    );

    assign w_rt_op = id_use_imm ? id_imm : w_rt_fwd;

    // Flush, load-use and idle cycles all present a clean all-zero bubble to EX.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every register
        // samples pre-edge values regardless of statement order.
        if (!rst || w_clear) begin
            r_valid   <= 1'b0;
            r_alu_sel <= '0;
            r_shift   <= '0;
            r_shamt   <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_wb_en   <= 1'b0;
            r_wb_addr <= '0;
            r_is_load <= 1'b0;
        end else if (w_capture) begin
            r_valid   <= 1'b1;
            r_alu_sel <= id_alu_sel;
            r_shift   <= id_shift;
            r_shamt   <= id_shamt;
            r_rs      <= w_rs_fwd;
            r_rt      <= w_rt_op;
            r_wb_en   <= id_wb_en;
            r_wb_addr <= id_wb_addr;
            r_is_load <= id_is_load;
        end
    end

    assign ex_valid   = r_valid;
    assign W_alu_sel  = r_alu_sel;
    assign W_shift    = r_shift;
    assign W_shamt    = r_shamt;
    assign W_rs       = r_rs;
    assign W_rt       = r_rt;
    assign ex_wb_en   = r_wb_en;
    assign ex_wb_addr = r_wb_addr;
    assign ex_is_load = r_is_load;

`ifdef ID_EX_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;

    // Both counters wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (id_valid && !w_id_ready) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_bubble) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign perf_stall_cnt  = r_stall_cnt;
    assign perf_bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX-side register contents are queued
// as ID stimulus is driven and compared one cycle later.
module tb_id_ex_stage;
    import cpu_defs::*;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic        id_ready;
    logic [2:0]  id_alu_sel;
    logic [1:0]  id_shift;
    logic [4:0]  id_shamt;
    logic [4:0]  id_rs_addr;
    logic [4:0]  id_rt_addr;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_imm;
    logic        id_use_imm;
    logic        id_wb_en;
    logic [4:0]  id_wb_addr;
    logic        id_is_load;
    logic        flush;
    logic        ex_ready;
    logic [31:0] ex_alu_res;
    logic        mem_wb_en;
    logic [4:0]  mem_wb_addr;
    logic [31:0] mem_wb_data;
    logic        ex_valid;
    logic [2:0]  W_alu_sel;
    logic [1:0]  W_shift;
    logic [4:0]  W_shamt;
    logic [31:0] W_rs;
    logic [31:0] W_rt;
    logic        ex_wb_en;
    logic [4:0]  ex_wb_addr;
    logic        ex_is_load;
`ifdef ID_EX_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int exp_stalls = 0;
    int exp_bubbles = 0;

    typedef struct {
        string       name;
        bit          full;
        logic        valid;
        logic [2:0]  alu;
        logic [1:0]  sh;
        logic [4:0]  shamt;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic        is_load;
    } exp_t;

    exp_t sb_q[$];

    id_ex_stage #(.DW(32), .RW(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_alu_sel  (id_alu_sel),
        .id_shift    (id_shift),
        .id_shamt    (id_shamt),
        .id_rs_addr  (id_rs_addr),
        .id_rt_addr  (id_rt_addr),
        .id_rs_data  (id_rs_data),
        .id_rt_data  (id_rt_data),
        .id_imm      (id_imm),
        .id_use_imm  (id_use_imm),
        .id_wb_en    (id_wb_en),
        .id_wb_addr  (id_wb_addr),
        .id_is_load  (id_is_load),
        .flush       (flush),
        .ex_ready    (ex_ready),
        .ex_alu_res  (ex_alu_res),
        .mem_wb_en   (mem_wb_en),
        .mem_wb_addr (mem_wb_addr),
        .mem_wb_data (mem_wb_data),
        .ex_valid    (ex_valid),
        .W_alu_sel   (W_alu_sel),
        .W_shift     (W_shift),
        .W_shamt     (W_shamt),
        .W_rs        (W_rs),
        .W_rt        (W_rt),
        .ex_wb_en    (ex_wb_en),
        .ex_wb_addr  (ex_wb_addr),
`ifdef ID_EX_PERF_EN
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_bubble_cnt (perf_bubble_cnt),
`endif
        .ex_is_load  (ex_is_load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard: each queued entry describes the register state after the next edge.
    always @(posedge clk) begin : sb_mon
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_checks++;
            if ({ex_valid, ex_wb_en} !== {e.valid, e.wb_en})
                $display("FAIL %s valid/wb_en: got %b/%b, expected %b/%b",
                         e.name, ex_valid, ex_wb_en, e.valid, e.wb_en);
            else
                n_pass++;
            if (e.full) begin
                n_checks++;
                if ({W_alu_sel, W_shift, W_shamt, W_rs, W_rt, ex_wb_addr, ex_is_load} !==
                    {e.alu, e.sh, e.shamt, e.rs, e.rt, e.wb_addr, e.is_load})
                    $display("FAIL %s payload: got alu=%0d sh=%0d shamt=%0d rs=%h rt=%h wa=%0d ld=%b, expected alu=%0d sh=%0d shamt=%0d rs=%h rt=%h wa=%0d ld=%b",
                             e.name, W_alu_sel, W_shift, W_shamt, W_rs, W_rt, ex_wb_addr, ex_is_load,
                             e.alu, e.sh, e.shamt, e.rs, e.rt, e.wb_addr, e.is_load);
                else
                    n_pass++;
            end
        end
    end

    function automatic void push_ins(input string name, input logic [2:0] alu, input logic [1:0] sh,
                                     input logic [4:0] shamt, input logic [31:0] rs, input logic [31:0] rt,
                                     input logic wb_en, input logic [4:0] wb_addr, input logic is_load);
        exp_t e;
        e.name = name; e.full = 1'b1; e.valid = 1'b1; e.alu = alu; e.sh = sh; e.shamt = shamt;
        e.rs = rs; e.rt = rt; e.wb_en = wb_en; e.wb_addr = wb_addr; e.is_load = is_load;
        sb_q.push_back(e);
    endfunction

    function automatic void push_bubble(input string name, input bit full);
        exp_t e;
        e.name = name; e.full = full; e.valid = 1'b0; e.alu = '0; e.sh = '0; e.shamt = '0;
        e.rs = '0; e.rt = '0; e.wb_en = 1'b0; e.wb_addr = '0; e.is_load = 1'b0;
        sb_q.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_id(input logic [2:0] alu, input logic [1:0] sh, input logic [4:0] shamt,
                            input logic [4:0] rs_a, input logic [31:0] rs_d,
                            input logic [4:0] rt_a, input logic [31:0] rt_d,
                            input logic use_imm, input logic [31:0] imm,
                            input logic wb_en, input logic [4:0] wb_a, input logic ld);
        id_valid   = 1'b1;
        id_alu_sel = alu;   id_shift   = sh;    id_shamt  = shamt;
        id_rs_addr = rs_a;  id_rs_data = rs_d;
        id_rt_addr = rt_a;  id_rt_data = rt_d;
        id_use_imm = use_imm; id_imm   = imm;
        id_wb_en   = wb_en; id_wb_addr = wb_a;  id_is_load = ld;
    endtask

    task automatic drive_idle();
        drive_id(3'd0, 2'd0, 5'd0, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0);
        id_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        ex_alu_res = 32'h0; mem_wb_en = 1'b0; mem_wb_addr = 5'd0; mem_wb_data = 32'h0;
        drive_id(ALU_ADD, SH_SLL, 5'd0, 5'd1, 32'h11, 5'd2, 32'h22, 1'b0, 32'h0, 1'b1, 5'd3, 1'b0);
        tick();
        tick();
        n_checks++;
        if (ex_valid !== 1'b0) $display("FAIL reset ex_valid: got %b, expected 0", ex_valid);
        else n_pass++;
        n_checks++;
        if (W_rs !== 32'h0) $display("FAIL reset W_rs: got %h, expected 0", W_rs);
        else n_pass++;
        n_checks++;
        if (W_rt !== 32'h0) $display("FAIL reset W_rt: got %h, expected 0", W_rt);
        else n_pass++;
        rst = 1'b1;
        drive_idle();
        #1;
        n_checks++;
        if (id_ready !== 1'b1) $display("FAIL reset id_ready: got %b, expected 1", id_ready);
        else n_pass++;
        push_bubble("idle_after_reset", 1'b1);
        tick();
    endtask

    task automatic test_ex_forward();
        drive_id(ALU_ADD, SH_SLL, 5'd0, 5'd1, 32'h1, 5'd2, 32'h2, 1'b0, 32'h0, 1'b1, 5'd3, 1'b0);
        push_ins("add_r3", ALU_ADD, SH_SLL, 5'd0, 32'h1, 32'h2, 1'b1, 5'd3, 1'b0);
        tick();
        ex_alu_res = 32'h10;
        drive_id(ALU_SUB, SH_SRL, 5'd4, 5'd3, 32'hDEAD, 5'd4, 32'h44, 1'b0, 32'h0, 1'b1, 5'd6, 1'b0);
        #1;
        n_checks++;
        if (id_ready !== 1'b1) $display("FAIL ex_fwd id_ready: got %b, expected 1", id_ready);
        else n_pass++;
        push_ins("ex_fwd_rs", ALU_SUB, SH_SRL, 5'd4, 32'h10, 32'h44, 1'b1, 5'd6, 1'b0);
        tick();
        drive_id(ALU_OR, SH_SLL, 5'd0, 5'd7, 32'h7, 5'd8, 32'h8, 1'b1, 32'h1234, 1'b1, 5'd3, 1'b0);
        push_ins("imm_rt", ALU_OR, SH_SLL, 5'd0, 32'h7, 32'h1234, 1'b1, 5'd3, 1'b0);
        tick();
        mem_wb_en = 1'b1; mem_wb_addr = 5'd3; mem_wb_data = 32'h20;
        drive_id(ALU_AND, SH_SLL, 5'd0, 5'd3, 32'hDEAD, 5'd9, 32'h9, 1'b0, 32'h0, 1'b1, 5'd10, 1'b0);
        push_ins("ex_over_mem", ALU_AND, SH_SLL, 5'd0, 32'h10, 32'h9, 1'b1, 5'd10, 1'b0);
        tick();
        ex_alu_res = 32'h30;
        drive_id(ALU_XOR, SH_SLL, 5'd0, 5'd1, 32'h1, 5'd3, 32'hBEEF, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0);
        push_ins("mem_fwd_rt", ALU_XOR, SH_SLL, 5'd0, 32'h1, 32'h20, 1'b0, 5'd0, 1'b0);
        tick();
        mem_wb_en = 1'b0;
        drive_idle();
        push_bubble("idle", 1'b0);
        tick();
    endtask

    task automatic test_load_use();
        drive_id(ALU_ADD, SH_SLL, 5'd0, 5'd1, 32'h100, 5'd0, 32'h0, 1'b1, 32'h4, 1'b1, 5'd5, 1'b1);
        push_ins("lw_r5", ALU_ADD, SH_SLL, 5'd0, 32'h100, 32'h4, 1'b1, 5'd5, 1'b1);
        tick();
        drive_id(ALU_ADD, SH_SLL, 5'd0, 5'd2, 32'h2, 5'd5, 32'hAAAA, 1'b0, 32'h0, 1'b1, 5'd7, 1'b0);
        #1;
        n_checks++;
        if (id_ready !== 1'b0) $display("FAIL load_use_rt id_ready: got %b, expected 0", id_ready);
        else n_pass++;
        exp_stalls++; exp_bubbles++;
        push_bubble("load_use_rt_bubble", 1'b1);
        tick();
        mem_wb_en = 1'b1; mem_wb_addr = 5'd5; mem_wb_data = 32'h55;
        #1;
        n_checks++;
        if (id_ready !== 1'b1) $display("FAIL after_bubble id_ready: got %b, expected 1", id_ready);
        else n_pass++;
        push_ins("load_use_rt_capture", ALU_ADD, SH_SLL, 5'd0, 32'h2, 32'h55, 1'b1, 5'd7, 1'b0);
        tick();
        mem_wb_en = 1'b0;
        drive_id(ALU_ADD, SH_SLL, 5'd0, 5'd2, 32'h200, 5'd0, 32'h0, 1'b1, 32'h8, 1'b1, 5'd8, 1'b1);
        push_ins("lw_r8", ALU_ADD, SH_SLL, 5'd0, 32'h200, 32'h8, 1'b1, 5'd8, 1'b1);
        tick();
        drive_id(ALU_SLT, SH_SLL, 5'd0, 5'd8, 32'h8888, 5'd2, 32'h2, 1'b0, 32'h0, 1'b1, 5'd12, 1'b0);
        #1;
        n_checks++;
        if (id_ready !== 1'b0) $display("FAIL load_use_rs id_ready: got %b, expected 0", id_ready);
        else n_pass++;
        exp_stalls++; exp_bubbles++;
        push_bubble("load_use_rs_bubble", 1'b1);
        tick();
        mem_wb_en = 1'b1; mem_wb_addr = 5'd8; mem_wb_data = 32'h88;
        push_ins("load_use_rs_capture", ALU_SLT, SH_SLL, 5'd0, 32'h88, 32'h2, 1'b1, 5'd12, 1'b0);
        tick();
        mem_wb_en = 1'b0;
        drive_id(ALU_ADD, SH_SLL, 5'd0, 5'd1, 32'h300, 5'd0, 32'h0, 1'b1, 32'h0, 1'b1, 5'd9, 1'b1);
        push_ins("lw_r9", ALU_ADD, SH_SLL, 5'd0, 32'h300, 32'h0, 1'b1, 5'd9, 1'b1);
        tick();
        drive_id(ALU_OR, SH_SRA, 5'd31, 5'd2, 32'h2, 5'd9, 32'h9999, 1'b1, 32'h40, 1'b1, 5'd13, 1'b0);
        #1;
        n_checks++;
        if (id_ready !== 1'b1) $display("FAIL imm_no_hazard id_ready: got %b, expected 1", id_ready);
        else n_pass++;
        push_ins("imm_no_hazard", ALU_OR, SH_SRA, 5'd31, 32'h2, 32'h40, 1'b1, 5'd13, 1'b0);
        tick();
    endtask

    task automatic test_reg_zero();
        ex_alu_res = 32'h77;
        drive_id(ALU_ADD, SH_SLL, 5'd0, 5'd1, 32'h1, 5'd2, 32'h2, 1'b0, 32'h0, 1'b1, 5'd0, 1'b0);
        push_ins("add_r0", ALU_ADD, SH_SLL, 5'd0, 32'h1, 32'h2, 1'b1, 5'd0, 1'b0);
        tick();
        mem_wb_en = 1'b1; mem_wb_addr = 5'd0; mem_wb_data = 32'h66;
        drive_id(ALU_ADD, SH_SLL, 5'd0, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 32'h0, 1'b1, 5'd0, 1'b1);
        #1;
        n_checks++;
        if (id_ready !== 1'b1) $display("FAIL r0_ex_alu id_ready: got %b, expected 1", id_ready);
        else n_pass++;
        push_ins("r0_no_ex_fwd", ALU_ADD, SH_SLL, 5'd0, 32'h0, 32'h0, 1'b1, 5'd0, 1'b1);
        tick();
        drive_id(ALU_XOR, SH_SLL, 5'd0, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0);
        #1;
        n_checks++;
        if (id_ready !== 1'b1) $display("FAIL r0_load id_ready: got %b, expected 1", id_ready);
        else n_pass++;
        push_ins("r0_after_lw_r0", ALU_XOR, SH_SLL, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
        tick();
        mem_wb_en = 1'b0;
    endtask

    task automatic test_back_pressure();
        drive_id(ALU_ADD, SH_SRL, 5'd3, 5'd1, 32'h5, 5'd2, 32'h6, 1'b0, 32'h0, 1'b1, 5'd11, 1'b0);
        push_ins("bp_head", ALU_ADD, SH_SRL, 5'd3, 32'h5, 32'h6, 1'b1, 5'd11, 1'b0);
        tick();
        ex_ready = 1'b0;
        drive_id(ALU_SUB, SH_SLL, 5'd0, 5'd3, 32'h33, 5'd4, 32'h44, 1'b0, 32'h0, 1'b1, 5'd14, 1'b0);
        for (int i = 0; i < 3; i++) begin
            flush = (i == 1);
            #1;
            n_checks++;
            if (id_ready !== 1'b0) $display("FAIL bp%0d id_ready: got %b, expected 0", i, id_ready);
            else n_pass++;
            exp_stalls++;
            if (i == 0) push_ins("bp_hold", ALU_ADD, SH_SRL, 5'd3, 32'h5, 32'h6, 1'b1, 5'd11, 1'b0);
            else if (i == 1) push_bubble("bp_flush", 1'b0);
            else push_bubble("bp_hold_flushed", 1'b0);
            tick();
        end
        flush = 1'b0;
        ex_ready = 1'b1;
        #1;
        n_checks++;
        if (id_ready !== 1'b1) $display("FAIL bp_release id_ready: got %b, expected 1", id_ready);
        else n_pass++;
        push_ins("bp_release", ALU_SUB, SH_SLL, 5'd0, 32'h33, 32'h44, 1'b1, 5'd14, 1'b0);
        tick();
        drive_idle();
        push_bubble("final_idle", 1'b0);
        tick();
    endtask

`ifdef ID_EX_PERF_EN
    task automatic test_perf();
        n_checks++;
        if (perf_bubble_cnt !== 32'(exp_bubbles))
            $display("FAIL perf_bubble_cnt: got %0d, expected %0d", perf_bubble_cnt, exp_bubbles);
        else n_pass++;
        n_checks++;
        if (perf_stall_cnt !== 32'(exp_stalls))
            $display("FAIL perf_stall_cnt: got %0d, expected %0d", perf_stall_cnt, exp_stalls);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_ex_forward();
        test_load_use();
        test_reg_zero();
        test_back_pressure();
`ifdef ID_EX_PERF_EN
        test_perf();
`endif
        tick();
        n_checks++;
        if (sb_q.size() != 0) $display("FAIL scoreboard_drain: got %0d entries, expected 0", sb_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
